// File: rtl/filtro_pkg.sv
// Shared state encoding for the debounce filter FSM.
// Pure declarations; no logic, no latency, no flow control.
package filtro_pkg;

   typedef enum logic [1:0] {
      ESTAVEL_0  = 2'd0,
      CONFIRMA_1 = 2'd1,
      ESTAVEL_1  = 2'd2,
      CONFIRMA_0 = 2'd3
   } estado_t;

   function automatic logic eh_confirma(input estado_t e);
      return (e == CONFIRMA_1) || (e == CONFIRMA_0);
   endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchronizer for one asynchronous level, cleared by synchronous reset.
// Latency 2 cycles; no backpressure, samples every clk edge.
module sincronizador_2ff (
   input  logic clk,
   input  logic rst,
   input  logic i_assinc,
   output logic o_sinc
);

   logic r_s1;
   logic r_s2;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= i_assinc;
         r_s2 <= r_s1;
      end
   end

   assign o_sinc = r_s2;

endmodule

// File: rtl/filtro_debounce.sv
// Debounces an async level: sync, then accept a change held N_ESTAVEL cycles; clean level + edge pulses.
// Change appears N_ESTAVEL+1 edges after first sample; no backpressure, all outputs registered.
module filtro_debounce
   import filtro_pkg::*;
#(
   parameter int N_ESTAVEL = 4,
   parameter int CONT_W    = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic entrada,
   output logic saida,
   output logic pulso_subida,
   output logic pulso_descida,
   output logic ocupado
);

   localparam logic [CONT_W-1:0] C_LIMITE = CONT_W'(N_ESTAVEL - 1);
   localparam logic [CONT_W-1:0] C_UM     = CONT_W'(1);

   logic w_s2;

   estado_t           r_estado;
   logic [CONT_W-1:0] r_cont;
   logic              r_saida;
   logic              r_subida;
   logic              r_descida;
   logic              r_ocupado;

   estado_t           w_estado_prox;
   logic [CONT_W-1:0] w_cont_prox;
   logic              w_saida_prox;
   logic              w_subida_prox;
   logic              w_descida_prox;

   sincronizador_2ff u_sinc (
      .clk      (clk),
      .rst      (rst),
      .i_assinc (entrada),
      .o_sinc   (w_s2)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_estado  <= ESTAVEL_0;
         r_cont    <= '0;
         r_saida   <= 1'b0;
         r_subida  <= 1'b0;
         r_descida <= 1'b0;
         r_ocupado <= 1'b0;
      end else begin
         r_estado  <= w_estado_prox;
         r_cont    <= w_cont_prox;
         r_saida   <= w_saida_prox;
         r_subida  <= w_subida_prox;
         r_descida <= w_descida_prox;
         r_ocupado <= eh_confirma(w_estado_prox);
      end
   end

   // A bounce during confirmation drops straight back to the stable state: no partial credit.
   always_comb begin
      w_estado_prox  = r_estado;
      w_cont_prox    = r_cont;
      w_saida_prox   = r_saida;
      w_subida_prox  = 1'b0;
      w_descida_prox = 1'b0;
      case (r_estado)
         ESTAVEL_0: begin
            if (w_s2) begin
               w_estado_prox = CONFIRMA_1;
               w_cont_prox   = C_UM;
            end else begin
               w_cont_prox   = '0;
            end
         end
         CONFIRMA_1: begin
            if (!w_s2) begin
               w_estado_prox = ESTAVEL_0;
               w_cont_prox   = '0;
            end else if (r_cont == C_LIMITE) begin
               w_estado_prox = ESTAVEL_1;
               w_saida_prox  = 1'b1;
               w_subida_prox = 1'b1;
               w_cont_prox   = '0;
            end else begin
               w_cont_prox   = r_cont + C_UM;
            end
         end
         ESTAVEL_1: begin
            if (!w_s2) begin
               w_estado_prox = CONFIRMA_0;
               w_cont_prox   = C_UM;
            end else begin
               w_cont_prox   = '0;
            end
         end
         CONFIRMA_0: begin
            if (w_s2) begin
               w_estado_prox  = ESTAVEL_1;
               w_cont_prox    = '0;
            end else if (r_cont == C_LIMITE) begin
               w_estado_prox  = ESTAVEL_0;
               w_saida_prox   = 1'b0;
               w_descida_prox = 1'b1;
               w_cont_prox    = '0;
            end else begin
               w_cont_prox    = r_cont + C_UM;
            end
         end
         default: begin
            w_estado_prox = ESTAVEL_0;
            w_cont_prox   = '0;
         end
      endcase
   end

   assign saida         = r_saida;
   assign pulso_subida  = r_subida;
   assign pulso_descida = r_descida;
   assign ocupado       = r_ocupado;

endmodule

// File: tb/tb_filtro_debounce.sv
// Directed bench for filtro_debounce: run-length reference model feeds an expected-value queue checked every edge.
module tb_filtro_debounce;

   localparam int N = 4;

   logic clk = 1'b0;
   logic rst;
   logic entrada;
   logic saida;
   logic pulso_subida;
   logic pulso_descida;
   logic ocupado;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic saida;
      logic sub;
      logic desc;
      logic ocup;
   } saidas_t;

   typedef struct {
      int i_sub;
      int i_desc;
      int n_sub;
      int n_desc;
      int n_ocup;
   } stats_t;

   saidas_t exp_q[$];

   // Reference model: counts consecutive synchronized samples that disagree with the accepted level.
   logic m_s1    = 1'b0;
   logic m_s2    = 1'b0;
   logic m_saida = 1'b0;
   int   m_run   = 0;

   filtro_debounce #(.N_ESTAVEL(N), .CONT_W(8)) dut (
      .clk           (clk),
      .rst           (rst),
      .entrada       (entrada),
      .saida         (saida),
      .pulso_subida  (pulso_subida),
      .pulso_descida (pulso_descida),
      .ocupado       (ocupado)
   );

   always #20 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
      end
   endtask

   task automatic modelo(input logic e, input logic r);
      saidas_t x;
      x.sub  = 1'b0;
      x.desc = 1'b0;
      if (r) begin
         m_s1    = 1'b0;
         m_s2    = 1'b0;
         m_saida = 1'b0;
         m_run   = 0;
      end else begin
         if (m_s2 != m_saida) begin
            m_run++;
            if (m_run == N) begin
               x.sub   = m_s2;
               x.desc  = !m_s2;
               m_saida = m_s2;
               m_run   = 0;
            end
         end else begin
            m_run = 0;
         end
         m_s2 = m_s1;
         m_s1 = e;
      end
      x.saida = m_saida;
      x.ocup  = (m_run != 0);
      exp_q.push_back(x);
   endtask

   task automatic ciclo(input logic e, input logic r, input bit glitch);
      saidas_t ex;
      saidas_t ob;
      @(negedge clk);
      rst     = r;
      entrada = e;
      if (glitch) begin
         #5  entrada = 1'b1;
         #13 entrada = e;
      end
      @(posedge clk);
      modelo(entrada, rst);
      #1;
      ob = {saida, pulso_subida, pulso_descida, ocupado};
      chk("fila_nao_vazia", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
         ex = exp_q.pop_front();
         chk("modelo", 32'(ob), 32'(ex));
      end
   endtask

   task automatic corre(input logic [31:0] padrao, input int n, input int rst_idx,
                        input bit glitch, output stats_t st);
      st = '{-1, -1, 0, 0, 0};
      for (int i = 0; i < n; i++) begin
         ciclo(padrao[i], (i == rst_idx), glitch);
         if (pulso_subida === 1'b1) begin
            if (st.i_sub < 0) st.i_sub = i;
            st.n_sub++;
         end
         if (pulso_descida === 1'b1) begin
            if (st.i_desc < 0) st.i_desc = i;
            st.n_desc++;
         end
         if (ocupado === 1'b1) st.n_ocup++;
      end
   endtask

   initial begin
      stats_t st;
      rst     = 1'b1;
      entrada = 1'b1;

      repeat (2) begin
         ciclo(1'b1, 1'b1, 1'b0);
         chk("reset_saidas", 32'({saida, pulso_subida, pulso_descida, ocupado}), 32'd0);
      end

      // Release with entrada already high: rises at the 6th edge after release.
      corre(32'hFFFF_FFFF, 10, -1, 1'b0, st);
      chk("rst_borda_subida", 32'(st.i_sub + 1), 32'd6);
      chk("rst_n_subida", 32'(st.n_sub), 32'd1);
      chk("rst_saida", 32'(saida), 32'd1);

      corre(32'h0000_0000, 10, -1, 1'b0, st);
      chk("queda_idx", 32'(st.i_desc), 32'd5);
      chk("queda_n_desc", 32'(st.n_desc), 32'd1);
      chk("queda_n_sub", 32'(st.n_sub), 32'd0);

      corre(32'hFFFF_FFFF, 10, -1, 1'b0, st);
      chk("subida_idx", 32'(st.i_sub), 32'd5);
      chk("subida_n", 32'(st.n_sub), 32'd1);
      chk("subida_ocupado", 32'(st.n_ocup), 32'd3);

      // Reset lands while CONFIRMA_0 is pending.
      corre(32'h0000_0000, 12, 3, 1'b0, st);
      chk("rstmeio_n_desc", 32'(st.n_desc), 32'd0);
      chk("rstmeio_ocupado", 32'(st.n_ocup), 32'd1);
      chk("rstmeio_saida", 32'(saida), 32'd0);

      corre(32'h0000_0000, 4, -1, 1'b1, st);
      chk("glitch13_n_sub", 32'(st.n_sub), 32'd0);
      chk("glitch13_ocupado", 32'(st.n_ocup), 32'd0);

      corre(32'h0000_000E, 12, -1, 1'b0, st);
      chk("glitch120_n_sub", 32'(st.n_sub), 32'd0);
      chk("glitch120_ocupado", 32'(st.n_ocup), 32'd3);
      chk("glitch120_fim", 32'({saida, ocupado}), 32'd0);

      // 1,0,1,1,0 then ones from index 5 on.
      corre(32'hFFFF_FFED, 14, -1, 1'b0, st);
      chk("bounce_idx", 32'(st.i_sub), 32'd10);
      chk("bounce_n_sub", 32'(st.n_sub), 32'd1);
      chk("bounce_n_desc", 32'(st.n_desc), 32'd0);

      // Input returns high just as the fall is being accepted.
      corre(32'hFFFF_FFF0, 14, -1, 1'b0, st);
      chk("toggle_desc_idx", 32'(st.i_desc), 32'd5);
      chk("toggle_sub_idx", 32'(st.i_sub), 32'd9);
      chk("toggle_n", 32'({st.n_desc[7:0], st.n_sub[7:0]}), 32'h0101);
      chk("toggle_saida", 32'(saida), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
